// File: rtl/sc_sched_pkg.sv
// Shared constants and types for the SC polar decoder sequencing controller.
package sc_sched_pkg;

  // Default code length exponent shared across the decoder (N = 2**SC_LOG_N).
  localparam int SC_LOG_N = 3;

  // Controller states.
  typedef enum logic [1:0] {
    SC_IDLE = 2'd0,
    SC_CALC = 2'd1,
    SC_LEAF = 2'd2,
    SC_DONE = 2'd3
  } sc_state_e;

  // PE array flag encoding: f (min-sum) vs g (sign-combine) function.
  localparam logic PE_F = 1'b1;
  localparam logic PE_G = 1'b0;

endpackage

// File: rtl/sc_sched_ctz.sv
// Count-trailing-zeros helper: gives the tree stage where the next bit's
// first (g) operation starts.
module sc_sched_ctz #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] count
);

  // Scan from MSB down so the lowest set bit wins; all-zero input yields 0.
  always_comb begin
    count = '0;
    for (int b = IN_W - 1; b >= 0; b--) begin
      if (value[b]) begin
        count = OUT_W'(b);
      end
    end
  end

endmodule

// File: rtl/sc_sched.sv
// Sequencing controller for the SC polar decoder: walks the SC tree of one
// codeword, issuing one f/g op per cycle and one leaf decision per bit.
module sc_sched
  import sc_sched_pkg::*;
#(
  parameter int LOG_N = SC_LOG_N,
  parameter int IDX_W = LOG_N,
  parameter int STG_W = $clog2(LOG_N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             op_flag,
  output logic [STG_W-1:0] op_stage,
  output logic [IDX_W-1:0] op_idx,
  output logic             leaf_valid,
  output logic [IDX_W-1:0] leaf_idx,
  input  logic             leaf_ack,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((1 << LOG_N) - 1);
  localparam logic [STG_W-1:0] TOP_STAGE = STG_W'(LOG_N - 1);

  sc_state_e        state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic             flag_q, flag_d;

  // i+1 is formed one bit wider so the ctz input can never wrap.
  logic [IDX_W:0]   i_next_wide;
  logic [STG_W-1:0] next_stage;

  assign i_next_wide = {1'b0, i_q} + (IDX_W + 1)'(1);

  sc_sched_ctz #(
    .IN_W  (IDX_W + 1),
    .OUT_W (STG_W)
  ) u_ctz (
    .value (i_next_wide),
    .count (next_stage)
  );

  // State, bit index, stage and flag registers with immediate abort on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SC_IDLE;
      i_q     <= '0;
      stage_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      stage_q <= stage_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state and output decode; op/leaf fields are zero outside their phase.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    stage_d    = stage_q;
    flag_d     = flag_q;
    op_valid   = 1'b0;
    op_flag    = 1'b0;
    op_stage   = '0;
    op_idx     = '0;
    leaf_valid = 1'b0;
    leaf_idx   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      SC_IDLE: begin
        if (start) begin
          state_d = SC_CALC;
          i_d     = '0;
          stage_d = TOP_STAGE;
          flag_d  = PE_F;
        end
      end
      SC_CALC: begin
        op_valid = 1'b1;
        op_flag  = flag_q;
        op_stage = stage_q;
        op_idx   = i_q;
        busy     = 1'b1;
        if (op_ready) begin
          if (stage_q != '0) begin
            stage_d = stage_q - STG_W'(1);
            flag_d  = PE_F;
          end else begin
            state_d = SC_LEAF;
          end
        end
      end
      SC_LEAF: begin
        leaf_valid = 1'b1;
        leaf_idx   = i_q;
        busy       = 1'b1;
        if (leaf_ack) begin
          if (i_q == LAST_IDX) begin
            state_d = SC_DONE;
          end else begin
            i_d     = i_next_wide[IDX_W-1:0];
            stage_d = next_stage;
            flag_d  = PE_G;
            state_d = SC_CALC;
          end
        end
      end
      SC_DONE: begin
        done    = 1'b1;
        state_d = SC_IDLE;
      end
      default: begin
        state_d = SC_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sc_sched.sv
// Directed self-checking bench for sc_sched with LOG_N=3 (N=8).
module tb_sc_sched;

  localparam int LOG_N = 3;
  localparam int IDX_W = 3;
  localparam int STG_W = 3;
  localparam int N     = 8;
  localparam int NOPS  = 14;

  localparam int ST_CALC = 1;
  localparam int ST_LEAF = 2;
  localparam int ST_DONE = 3;
  localparam int ST_IDLE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             op_valid;
  logic             op_ready;
  logic             op_flag;
  logic [STG_W-1:0] op_stage;
  logic [IDX_W-1:0] op_idx;
  logic             leaf_valid;
  logic [IDX_W-1:0] leaf_idx;
  logic             leaf_ack;
  logic             busy;
  logic             done;

  logic [13:0]      all_out;

  int checks   = 0;
  int failures = 0;

  // Hand-derived op schedule for N=8: (flag, stage, idx) per transferred op.
  int exp_flag  [NOPS] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0};
  int exp_stage [NOPS] = '{2, 1, 0, 0, 1, 0, 0, 2, 1, 0, 0, 1, 0, 0};
  int exp_idx   [NOPS] = '{0, 0, 0, 1, 2, 2, 3, 4, 4, 4, 5, 6, 6, 7};

  sc_sched #(.LOG_N(LOG_N), .IDX_W(IDX_W), .STG_W(STG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_flag    (op_flag),
    .op_stage   (op_stage),
    .op_idx     (op_idx),
    .leaf_valid (leaf_valid),
    .leaf_idx   (leaf_idx),
    .leaf_ack   (leaf_ack),
    .busy       (busy),
    .done       (done)
  );

  assign all_out = {op_valid, op_flag, op_stage, op_idx, leaf_valid, leaf_idx, busy, done};

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic r, input logic a);
    start    = s;
    op_ready = r;
    leaf_ack = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checkOutput(tag, all_out, 0);
    end
  endtask

  // Runs one codeword from IDLE; entered and left at a negedge.
  task automatic runWord(input bit hold_start, input int op_stall_k, input int op_stall_len,
                         input int leaf_stall_i, input int leaf_stall_len, input int busy_start_cyc,
                         input bit start_in_done, input int abort_leaf_i, input int exp_done_cyc);
    int cyc      = 0;
    int k        = 0;
    int leaf_k   = 0;
    int op_wait  = 0;
    int lf_wait  = 0;
    int done_cyc = -1;
    int mstate   = ST_CALC;
    bit finished = 1'b0;
    bit aborted  = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1 start = hold_start;
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      applyStimulus(hold_start || (cyc == busy_start_cyc), 1'b1, 1'b0);
      case (mstate)
        ST_CALC: begin
          checkOutput("calc_op_valid", op_valid, 1);
          checkOutput("calc_leaf_valid", leaf_valid, 0);
          checkOutput("calc_busy", busy, 1);
          checkOutput("op_flag", op_flag, exp_flag[k]);
          checkOutput("op_stage", op_stage, exp_stage[k]);
          checkOutput("op_idx", op_idx, exp_idx[k]);
          if (k == op_stall_k && op_wait < op_stall_len) begin
            op_ready = 1'b0;
            op_wait++;
          end else begin
            k++;
            if (k == NOPS || exp_idx[k] != exp_idx[k-1]) mstate = ST_LEAF;
          end
        end
        ST_LEAF: begin
          checkOutput("leaf_valid", leaf_valid, 1);
          checkOutput("leaf_op_valid", op_valid, 0);
          checkOutput("leaf_busy", busy, 1);
          checkOutput("leaf_idx", leaf_idx, leaf_k);
          if (leaf_k == abort_leaf_i) begin
            #2 rst = 1'b1;
            #1 checkOutput("abort_outputs", all_out, 0);
            @(negedge clk);
            checkOutput("abort_held", all_out, 0);
            rst      = 1'b0;
            aborted  = 1'b1;
            finished = 1'b1;
          end else if (leaf_k == leaf_stall_i && lf_wait < leaf_stall_len) begin
            lf_wait++;
          end else begin
            leaf_ack = 1'b1;
            leaf_k++;
            mstate = (leaf_k == N) ? ST_DONE : ST_CALC;
          end
        end
        ST_DONE: begin
          checkOutput("done_pulse", done, 1);
          checkOutput("done_busy", busy, 0);
          checkOutput("done_op_valid", op_valid, 0);
          checkOutput("done_leaf_valid", leaf_valid, 0);
          done_cyc = cyc;
          if (start_in_done) start = 1'b1;
          mstate = ST_IDLE;
        end
        default: begin
          checkOutput("idle_done", done, 0);
          checkOutput("idle_busy", busy, 0);
          checkOutput("idle_op_valid", op_valid, 0);
          start    = hold_start;
          finished = 1'b1;
        end
      endcase
    end
    checkOutput("no_timeout", finished, 1);
    if (!aborted) begin
      checkOutput("op_count", k, NOPS);
      checkOutput("done_cycle", done_cyc, exp_done_cyc);
    end
  endtask

  // Directed sequence covering reset, nominal run, stalls, stray starts and abort.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", all_out, 0);
    rst = 1'b0;

    $display("[TB] idle after reset");
    checkIdle("idle_no_start", 20);

    $display("[TB] start held high, then restart from IDLE");
    runWord(1'b1, -1, 0, -1, 0, -1, 1'b0, -1, 23);
    runWord(1'b0, -1, 0, -1, 0, -1, 1'b0, -1, 23);
    checkIdle("idle_after_nominal", 3);

    $display("[TB] op_ready stall on (g2,4)");
    runWord(1'b0, 7, 3, -1, 0, -1, 1'b0, -1, 26);
    checkIdle("idle_after_op_stall", 2);

    $display("[TB] leaf_ack delayed at i=3");
    runWord(1'b0, -1, 0, 3, 4, -1, 1'b0, -1, 27);
    checkIdle("idle_after_leaf_stall", 2);

    $display("[TB] start pulses while busy and in DONE");
    runWord(1'b0, -1, 0, -1, 0, 7, 1'b1, -1, 23);
    checkIdle("idle_after_stray_start", 4);

    $display("[TB] async reset mid-LEAF at i=5, then full rerun");
    runWord(1'b0, -1, 0, -1, 0, -1, 1'b0, 5, 0);
    checkIdle("idle_after_abort", 2);
    runWord(1'b0, -1, 0, -1, 0, -1, 1'b0, -1, 23);
    checkIdle("idle_final", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
